// File: rtl/serdes_test_pkg.sv
// Shared definitions for the SERDES test frame generator: FSM encoding,
// framing constants, payload pattern codes and PRBS31 taps.
package serdes_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SOF1    = 2'd1,
        ST_SOF2    = 2'd2,
        ST_PAYLOAD = 2'd3
    } fsm_state_e;

    localparam logic [1:0] PAT_CNT  = 2'd0;
    localparam logic [1:0] PAT_PRBS = 2'd1;
    localparam logic [1:0] PAT_IDLE = 2'd2;

    // x^31 + x^28 + 1, taps expressed as state bit indices
    localparam int PRBS_TAP_HI = 30;
    localparam int PRBS_TAP_LO = 27;

    localparam logic [7:0]  SOF1_8B_CTRL = 8'h01;
    localparam logic [63:0] SOF1_8B_DATA = 64'h5050_5050_5050_50BC;
    localparam logic [7:0]  SOF1_66_CTRL = 8'h80;
    localparam logic [63:0] SOF1_66_DATA = 64'hFD50_5050_5050_5050;
    localparam logic [7:0]  SOF2_8B_CTRL = 8'h00;
    localparam logic [63:0] SOF2_8B_DATA = 64'h5050_5050_5050_5050;
    localparam logic [7:0]  SOF2_66_CTRL = 8'h01;
    localparam logic [63:0] SOF2_66_DATA = 64'h5050_5050_5050_50FB;
    localparam logic [7:0]  IDLE_66_CTRL = 8'hFF;
    localparam logic [63:0] IDLE_66_DATA = 64'h0707_0707_0707_0707;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [63:0] data;
    } tx_word_t;

    function automatic tx_word_t sof1_word(input logic sel66);
        return sel66 ? tx_word_t'{SOF1_66_CTRL, SOF1_66_DATA}
                     : tx_word_t'{SOF1_8B_CTRL, SOF1_8B_DATA};
    endfunction

    function automatic tx_word_t sof2_word(input logic sel66);
        return sel66 ? tx_word_t'{SOF2_66_CTRL, SOF2_66_DATA}
                     : tx_word_t'{SOF2_8B_CTRL, SOF2_8B_DATA};
    endfunction

    // 8b10b idle fill reuses the SOF1 comma word
    function automatic tx_word_t idle_word(input logic sel66);
        return sel66 ? tx_word_t'{IDLE_66_CTRL, IDLE_66_DATA}
                     : tx_word_t'{SOF1_8B_CTRL, SOF1_8B_DATA};
    endfunction

endpackage

// File: rtl/serdes_prbs31_gen.sv
// PRBS31 source producing 64 bits per clock, first generated bit at data[63].
// data always shows the next word; advance commits it, load reseeds.
module serdes_prbs31_gen
    import serdes_test_pkg::*;
(
    input  logic        I_txoutclk,
    input  logic [30:0] seed,
    input  logic        load,
    input  logic        advance,
    output logic [63:0] data
);

    logic [30:0] state_q;
    logic [30:0] state_d;

    always_comb begin
        state_d = state_q;
        data    = '0;
        for (int i = 63; i >= 0; i--) begin
            data[i] = state_d[PRBS_TAP_HI] ^ state_d[PRBS_TAP_LO];
            state_d = {state_d[29:0], data[i]};
        end
    end

    always_ff @(posedge I_txoutclk) begin
        if (load)
            state_q <= seed;
        else if (advance)
            state_q <= state_d;
    end

endmodule

// File: rtl/serdes_test_frame_gen.sv
// Multi-lane SERDES test frame generator: SOF1/SOF2 header plus counter,
// PRBS31 or idle payload, muxed per lane against mission traffic.
module serdes_test_frame_gen
    import serdes_test_pkg::*;
#(
    parameter int          P_LANES     = 2,
    parameter int          P_LEN_W     = 16,
    parameter logic [30:0] P_PRBS_SEED = 31'h7FFF_FFFF
) (
    input  logic                   I_txoutclk,
    input  logic                   I_txoutrst,
    input  logic [8*P_LANES-1:0]   I_txctrl,
    input  logic [64*P_LANES-1:0]  I_txdata,
    input  logic                   I_8b10b_or_64b66b_sel,
    input  logic [P_LANES-1:0]     I_test_en,
    input  logic [1:0]             I_pattern_sel,
    input  logic [P_LEN_W-1:0]     I_frame_len,
    input  logic [15:0]            I_frame_num,
    input  logic                   I_start,
    input  logic                   I_stop,
    output logic                   O_busy,
    output logic                   O_done,
    output logic [15:0]            O_frame_cnt,
    output logic [8*P_LANES-1:0]   O_txctrl,
    output logic [64*P_LANES-1:0]  O_txdata
);

    fsm_state_e         state_q, state_d;
    logic [P_LEN_W-1:0] idx_q, idx_d, len_q;
    logic [15:0]        num_q, frame_cnt_q;
    logic [1:0]         pat_q;
    logic               stop_pend_q, done_q;
    logic               start_acc, frame_end, cnt_hit;
    logic               use_prbs;
    tx_word_t           common_w;
    logic [15:0]        idx16;

    assign cnt_hit = (num_q != 16'd0) && (frame_cnt_q + 16'd1 == num_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        start_acc = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_start && !I_stop) begin
                    start_acc = 1'b1;
                    state_d   = ST_SOF1;
                    idx_d     = '0;
                end
            end
            ST_SOF1: begin
                state_d = ST_SOF2;
                idx_d   = P_LEN_W'(1);
            end
            ST_SOF2: begin
                state_d = ST_PAYLOAD;
                idx_d   = P_LEN_W'(2);
            end
            ST_PAYLOAD: begin
                if (idx_q == len_q) begin
                    frame_end = 1'b1;
                    idx_d     = '0;
                    // a stop raised on the last word still ends the burst here
                    state_d   = (cnt_hit || stop_pend_q || I_stop) ? ST_IDLE : ST_SOF1;
                end else begin
                    idx_d = idx_q + P_LEN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_txoutclk) begin
        if (I_txoutrst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= P_LEN_W'(2);
            num_q       <= '0;
            pat_q       <= PAT_CNT;
            frame_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= frame_end && cnt_hit;
            if (start_acc) begin
                len_q       <= (I_frame_len < P_LEN_W'(2)) ? P_LEN_W'(2) : I_frame_len;
                num_q       <= I_frame_num;
                pat_q       <= I_pattern_sel;
                frame_cnt_q <= '0;
            end else if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (state_d == ST_IDLE)
                stop_pend_q <= 1'b0;
            else if (state_q != ST_IDLE && I_stop)
                stop_pend_q <= 1'b1;
        end
    end

    assign O_busy      = (state_q != ST_IDLE);
    assign O_done      = done_q;
    assign O_frame_cnt = frame_cnt_q;
    assign idx16       = 16'(idx_q);

    // Lane-independent part of the next word; PRBS lanes substitute their own data
    always_comb begin
        common_w = idle_word(I_8b10b_or_64b66b_sel);
        use_prbs = 1'b0;
        case (state_q)
            ST_SOF1: common_w = sof1_word(I_8b10b_or_64b66b_sel);
            ST_SOF2: common_w = sof2_word(I_8b10b_or_64b66b_sel);
            ST_PAYLOAD: begin
                case (pat_q)
                    PAT_PRBS: begin
                        common_w = tx_word_t'{8'h00, 64'h0};
                        use_prbs = 1'b1;
                    end
                    PAT_IDLE: common_w = idle_word(I_8b10b_or_64b66b_sel);
                    default:  common_w = tx_word_t'{8'h00, {idx16, 16'h0000, idx16, idx16}};
                endcase
            end
            default: ;
        endcase
    end

    for (genvar l = 0; l < P_LANES; l++) begin : g_lane
        logic [63:0] prbs_data;
        tx_word_t    gen_q;

        serdes_prbs31_gen u_prbs (
            .I_txoutclk (I_txoutclk),
            .seed       (P_PRBS_SEED ^ 31'(l)),
            .load       (I_txoutrst | start_acc),
            .advance    (state_q == ST_PAYLOAD),
            .data       (prbs_data)
        );

        always_ff @(posedge I_txoutclk) begin
            if (I_txoutrst)
                gen_q <= tx_word_t'{SOF1_8B_CTRL, SOF1_8B_DATA};
            else
                gen_q <= use_prbs ? tx_word_t'{8'h00, prbs_data} : common_w;
        end

        assign O_txctrl[8*l +: 8]  = I_test_en[l] ? gen_q.ctrl : I_txctrl[8*l +: 8];
        assign O_txdata[64*l +: 64] = I_test_en[l] ? gen_q.data : I_txdata[64*l +: 64];
    end

endmodule

// File: tb/tb_serdes_test_frame_gen.sv
// Directed, table-driven bench for serdes_test_frame_gen (2 lanes).
module tb_serdes_test_frame_gen;

    localparam logic [63:0] D_S1_8B  = 64'h5050_5050_5050_50BC;
    localparam logic [63:0] D_S2_8B  = 64'h5050_5050_5050_5050;
    localparam logic [63:0] D_S1_66  = 64'hFD50_5050_5050_5050;
    localparam logic [63:0] D_S2_66  = 64'h5050_5050_5050_50FB;
    localparam logic [63:0] D_ID_66  = 64'h0707_0707_0707_0707;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  txctrl;
    logic [127:0] txdata;
    logic         sel66;
    logic [1:0]   test_en;
    logic [1:0]   pat;
    logic [15:0]  flen, fnum;
    logic         start, stop;
    logic         busy, done;
    logic [15:0]  fcnt;
    logic [15:0]  o_ctrl;
    logic [127:0] o_data;

    int n_chk = 0;
    int n_fail = 0;

    serdes_test_frame_gen dut (
        .I_txoutclk            (clk),
        .I_txoutrst            (rst),
        .I_txctrl              (txctrl),
        .I_txdata              (txdata),
        .I_8b10b_or_64b66b_sel (sel66),
        .I_test_en             (test_en),
        .I_pattern_sel         (pat),
        .I_frame_len           (flen),
        .I_frame_num           (fnum),
        .I_start               (start),
        .I_stop                (stop),
        .O_busy                (busy),
        .O_done                (done),
        .O_frame_cnt           (fcnt),
        .O_txctrl              (o_ctrl),
        .O_txdata              (o_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic        stop;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
        logic [7:0]  ctrl;
        logic [63:0] data;
    } vec_t;

    vec_t vt[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] cw(input logic [15:0] i);
        return {i, 16'h0000, i, i};
    endfunction

    function automatic vec_t mk(input logic st, input logic sp, input logic b, input logic d,
                                input logic [15:0] c, input logic [7:0] ct, input logic [63:0] dt);
        vec_t v;
        v.start = st; v.stop = sp; v.busy = b; v.done = d;
        v.cnt = c; v.ctrl = ct; v.data = dt;
        return v;
    endfunction

    // Bit-serial reference LFSR: x^31 + x^28 + 1, first bit lands in w[63]
    task automatic prbs_ref(input logic [30:0] si, output logic [30:0] so, output logic [63:0] w);
        logic b;
        so = si;
        w  = '0;
        for (int k = 0; k < 64; k++) begin
            b  = so[30] ^ so[27];
            w  = {w[62:0], b};
            so = {so[29:0], b};
        end
    endtask

    task automatic chk_lanes(input string nm, input logic [7:0] ct, input logic [63:0] dt);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("%s ctrl%0d", nm, l), 64'(o_ctrl[8*l +: 8]), 64'(ct));
            chk($sformatf("%s data%0d", nm, l), o_data[64*l +: 64], dt);
        end
    endtask

    initial begin
        logic [30:0] rs[2];
        logic [63:0] w;
        int          kind[11];

        rst = 1'b1; txctrl = '0; txdata = '0; sel66 = 1'b0; test_en = 2'b11;
        pat = 2'd0; flen = 16'd5; fnum = 16'd2; start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst cnt", 64'(fcnt), 64'd0);
        chk_lanes("rst word", 8'h01, D_S1_8B);
        rst = 1'b0;
        tick();

        // 8b10b, len 5, num 2, counter; row 5 is a start while busy, row 14 start+stop in IDLE
        vt[0]  = mk(1, 0, 1, 0, 0, 8'h01, D_S1_8B);
        vt[1]  = mk(0, 0, 1, 0, 0, 8'h01, D_S1_8B);
        vt[2]  = mk(0, 0, 1, 0, 0, 8'h00, D_S2_8B);
        vt[3]  = mk(0, 0, 1, 0, 0, 8'h00, cw(2));
        vt[4]  = mk(0, 0, 1, 0, 0, 8'h00, cw(3));
        vt[5]  = mk(1, 0, 1, 0, 0, 8'h00, cw(4));
        vt[6]  = mk(0, 0, 1, 0, 1, 8'h00, cw(5));
        vt[7]  = mk(0, 0, 1, 0, 1, 8'h01, D_S1_8B);
        vt[8]  = mk(0, 0, 1, 0, 1, 8'h00, D_S2_8B);
        vt[9]  = mk(0, 0, 1, 0, 1, 8'h00, cw(2));
        vt[10] = mk(0, 0, 1, 0, 1, 8'h00, cw(3));
        vt[11] = mk(0, 0, 1, 0, 1, 8'h00, cw(4));
        vt[12] = mk(0, 0, 0, 1, 2, 8'h00, cw(5));
        vt[13] = mk(0, 0, 0, 0, 2, 8'h01, D_S1_8B);
        vt[14] = mk(1, 1, 0, 0, 2, 8'h01, D_S1_8B);
        vt[15] = mk(0, 0, 0, 0, 2, 8'h01, D_S1_8B);
        for (int i = 0; i < 16; i++) begin
            start = vt[i].start;
            stop  = vt[i].stop;
            tick();
            chk($sformatf("tbl%0d busy", i), 64'(busy), 64'(vt[i].busy));
            chk($sformatf("tbl%0d done", i), 64'(done), 64'(vt[i].done));
            chk($sformatf("tbl%0d cnt", i), 64'(fcnt), 64'(vt[i].cnt));
            chk_lanes($sformatf("tbl%0d", i), vt[i].ctrl, vt[i].data);
        end
        start = 1'b0; stop = 1'b0;

        // 64b66b, len 0 clamps to 2, continuous, stop raised in SOF1 of frame 3
        sel66 = 1'b1; flen = 16'd0; fnum = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_lanes("66 start", 8'hFF, D_ID_66);
        kind = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 0, 0};
        for (int k = 0; k < 10; k++) begin
            stop = (k == 6);
            tick();
            chk($sformatf("66 e%0d busy", k + 1), 64'(busy), 64'(k < 8));
            chk($sformatf("66 e%0d done", k + 1), 64'(done), 64'd0);
            case (kind[k])
                1: chk_lanes($sformatf("66 e%0d", k + 1), 8'h80, D_S1_66);
                2: chk_lanes($sformatf("66 e%0d", k + 1), 8'h01, D_S2_66);
                3: chk_lanes($sformatf("66 e%0d", k + 1), 8'h00, cw(2));
                default: chk_lanes($sformatf("66 e%0d", k + 1), 8'hFF, D_ID_66);
            endcase
        end
        stop = 1'b0;
        chk("66 cnt", 64'(fcnt), 64'd3);

        // PRBS31, 8b10b, len 4, continuous, stop mid-payload of frame 2
        sel66 = 1'b0; pat = 2'd1; flen = 16'd4; fnum = 16'd0;
        rs[0] = 31'h7FFF_FFFF;
        rs[1] = 31'h7FFF_FFFE;
        start = 1'b1;
        tick();
        start = 1'b0;
        kind = '{1, 2, 3, 3, 3, 1, 2, 3, 3, 3, 0};
        for (int k = 0; k < 11; k++) begin
            stop = (k == 8);
            tick();
            chk($sformatf("prbs e%0d busy", k + 1), 64'(busy), 64'(k < 9));
            chk($sformatf("prbs e%0d done", k + 1), 64'(done), 64'd0);
            case (kind[k])
                1: chk_lanes($sformatf("prbs e%0d", k + 1), 8'h01, D_S1_8B);
                2: chk_lanes($sformatf("prbs e%0d", k + 1), 8'h00, D_S2_8B);
                3: begin
                    for (int l = 0; l < 2; l++) begin
                        prbs_ref(rs[l], rs[l], w);
                        chk($sformatf("prbs e%0d ctrl%0d", k + 1, l), 64'(o_ctrl[8*l +: 8]), 64'h0);
                        chk($sformatf("prbs e%0d data%0d", k + 1, l), o_data[64*l +: 64], w);
                    end
                end
                default: chk_lanes($sformatf("prbs e%0d", k + 1), 8'h01, D_S1_8B);
            endcase
        end
        stop = 1'b0;
        chk("prbs cnt", 64'(fcnt), 64'd2);

        // Per-lane mission bypass, zero latency
        txdata  = {64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF};
        txctrl  = 16'hA55A;
        test_en = 2'b01;
        #1;
        chk("byp l0 ctrl", 64'(o_ctrl[7:0]), 64'h01);
        chk("byp l0 data", o_data[63:0], D_S1_8B);
        chk("byp l1 ctrl", 64'(o_ctrl[15:8]), 64'hA5);
        chk("byp l1 data", o_data[127:64], 64'hDEAD_BEEF_CAFE_F00D);
        test_en = 2'b00;
        #1;
        chk("byp l0 mission", o_data[63:0], 64'h0123_4567_89AB_CDEF);
        chk("byp l0 mctrl", 64'(o_ctrl[7:0]), 64'h5A);
        test_en = 2'b11;

        // Counter, len 3, continuous; ignored start while busy, then reset mid-payload
        pat = 2'd0; flen = 16'd3; fnum = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("rb cnt1", 64'(fcnt), 64'd1);
        chk_lanes("rb sof2", 8'h00, D_S2_8B);
        start = 1'b1; flen = 16'd0;
        tick();
        start = 1'b0;
        chk("rb busy ign", 64'(busy), 64'd1);
        chk("rb cnt ign", 64'(fcnt), 64'd1);
        chk_lanes("rb pay", 8'h00, cw(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb busy", 64'(busy), 64'd0);
        chk("rb cnt0", 64'(fcnt), 64'd0);
        chk("rb done", 64'(done), 64'd0);
        chk_lanes("rb idle", 8'h01, D_S1_8B);
        tick();
        chk("rb done2", 64'(done), 64'd0);
        chk("rb busy2", 64'(busy), 64'd0);
        chk_lanes("rb idle2", 8'h01, D_S1_8B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_test_frame_gen.md
SERDES_TEST_FRAME_GEN -- requirements
Module: serdes_test_frame_gen

Interface
REQ-001 Parameter P_LANES, 2, number of independent 64-bit tx lanes sharing one frame engine.
REQ-002 Parameter P_LEN_W, 16, width of frame-length and word-index counters.
REQ-003 Parameter P_PRBS_SEED, 31'h7FFF_FFFF, base PRBS31 seed; lane l seeds with P_PRBS_SEED ^ l, never zero.
REQ-004 I_txoutclk  in  1  sole clock.
REQ-005 I_txoutrst  in  1  reset, synchronous, active-high.
REQ-006 I_txctrl  in  8*P_LANES  mission ctrl bits, lane l at [8l+7:8l].
REQ-007 I_txdata  in  64*P_LANES  mission data, lane l at [64l+63:64l].
REQ-008 I_8b10b_or_64b66b_sel  in  1  0 = 8b10b, 1 = 64b66b framing.
REQ-009 I_test_en  in  P_LANES  per-lane select of generator output.
REQ-010 I_pattern_sel  in  2  payload: 0 counter, 1 PRBS31, 2 idle fill, 3 reserved (treated as 0).
REQ-011 I_frame_len  in  P_LEN_W  last word index of a frame, header included.
REQ-012 I_frame_num  in  16  frames per burst; 0 = continuous.
REQ-013 I_start  in  1  single-cycle burst start request.
REQ-014 I_stop  in  1  single-cycle graceful stop request.
REQ-015 O_busy  out  1  high from SOF1 entry until return to IDLE.
REQ-016 O_done  out  1  one-cycle pulse when a counted burst completes.
REQ-017 O_frame_cnt  out  16  frames completed in current/last burst.
REQ-018 O_txctrl  out  8*P_LANES;  O_txdata  out  64*P_LANES  per-lane output.

Function
REQ-019 FSM states IDLE, SOF1, SOF2, PAYLOAD; IDLE->SOF1 on I_start; SOF1->SOF2; SOF2->PAYLOAD.
REQ-020 I_frame_len, I_frame_num, I_pattern_sel shall be latched on the accepted I_start and held for the burst; latched length below 2 shall be clamped to 2.
REQ-021 Word index shall be 0 in SOF1, 1 in SOF2, increment in PAYLOAD; at index == latched length the frame ends and O_frame_cnt increments.
REQ-022 At frame end: if I_frame_num != 0 and O_frame_cnt+1 == I_frame_num, or a stop is pending, go IDLE; else go SOF1.
REQ-023 O_done shall pulse in the cycle after a counted-burst end; stop-terminated or continuous bursts shall not pulse O_done.
REQ-024 I_stop in SOF1/SOF2/PAYLOAD shall set a pending flag; current frame completes in full; flag cleared on IDLE entry.
REQ-025 I_start while busy shall be ignored; I_start and I_stop together in IDLE: stop wins, FSM stays IDLE.
REQ-026 O_frame_cnt shall clear on accepted I_start and hold after burst end.
REQ-027 SOF1 word: 8b10b ctrl 8'h01 data 64'h50505050505050BC; 64b66b ctrl 8'h80 data 64'hFD50505050505050.
REQ-028 SOF2 word: 8b10b ctrl 8'h00 data 64'h5050505050505050; 64b66b ctrl 8'h01 data 64'h50505050505050FB.
REQ-029 PAYLOAD ctrl 8'h00; counter data {idx,16'h0,idx,idx} (idx truncated/zero-extended to 16 bits); PRBS31 data 64 next bits of x^31+x^28+1, MSB first.
REQ-030 PRBS state reseeded on accepted I_start, advances only in PAYLOAD, continuous across frames of a burst.
REQ-031 IDLE state and pattern 2 payload emit idle fill: 8b10b as SOF1 word; 64b66b ctrl 8'hFF data 64'h0707070707070707.
REQ-032 Generator word registered: appears on outputs one cycle after the FSM state that produces it.
REQ-033 Output mux per lane combinational: I_test_en[l] ? generator : I_txctrl/I_txdata lane l, zero latency.
REQ-034 Framing select changes mid-burst take effect on the next generated word; no FSM disturbance.

Reset
REQ-035 On I_txoutrst at any clock: FSM IDLE, counters, stop flag, O_busy, O_done, O_frame_cnt zero, PRBS reseeded, generator registers hold 8b10b idle word; no O_done on reset mid-burst.

Structure
REQ-036 Shared package serdes_test_pkg: FSM state encoding, SOF/idle ctrl/data constants, pattern_sel codes, PRBS31 taps.
REQ-037 Sub-module serdes_prbs31_gen (64 bits/clock, seed/load/advance inputs), one instance per lane.

Verification
REQ-038 8b10b, len 5, num 2, counter -> frames of 6 words, payload idx 2..5 e.g. 64'h0002_0000_0002_0002, O_done one pulse, O_frame_cnt 2.
REQ-039 64b66b, len 0 (clamped to 2) -> SOF1 ctrl 80, SOF2 ctrl 01, one payload word idx 2, repeating.
REQ-040 num 0, PRBS31, I_stop mid-PAYLOAD -> frame completes, IDLE fill, O_busy low, no O_done; lane data matches reference model per seed.
REQ-041 I_test_en = 2'b01 -> lane 0 generator, lane 1 equals I_txdata/I_txctrl same cycle.
REQ-042 Reset asserted mid-PAYLOAD -> next cycle O_busy 0, O_frame_cnt 0, idle word; I_start while busy ignored, counts unchanged.
